// File: rtl/spi_pkg.sv
// Shared SPI/RAM definitions: FSM states, command codes and word widths.
package spi_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // Word handed to the RAM: command in the top two bits, address or data below.
    typedef struct packed {
        logic [1:0]        cmd;
        logic [DATA_W-1:0] payload;
    } rx_word_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-facing parallel word and read-back handshake.
interface spi_slave_if
    import spi_pkg::*;
();

    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    rx_word_t          rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );

endinterface

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM: deserialises 10-bit words
// and serialises RAM read data back on MISO.
module spi_slave
    import spi_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);

    state_e              state;
    state_e              next_state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [FRAME_W-2:0]  rx_shift;
    logic [DATA_W-1:0]   tx_shift;
    logic [CNT_W-1:0]    tx_cnt;
    logic                tx_active;
    logic                rd_addr_seen;

    logic                shift_en_c;
    logic                frame_done_c;
    logic                tx_load_c;
    logic                tx_shift_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and datapath enables.
    always_comb begin
        next_state   = state;
        shift_en_c   = 1'b0;
        frame_done_c = 1'b0;
        tx_load_c    = 1'b0;
        tx_shift_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.SS_n) begin
                    next_state = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    next_state = IDLE;
                end else if (!bus.MOSI) begin
                    next_state = WRITE;
                end else if (rd_addr_seen) begin
                    next_state = READ_DATA;
                end else begin
                    next_state = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    next_state = IDLE;
                end else if (bit_cnt < CNT_W'(FRAME_W)) begin
                    shift_en_c   = 1'b1;
                    frame_done_c = (bit_cnt == CNT_W'(FRAME_W - 1));
                end else if (state == READ_DATA) begin
                    // Frame finished; only the read-data readout phase listens to tx_valid.
                    if (!tx_active) begin
                        tx_load_c = bus.tx_valid;
                    end else begin
                        tx_shift_c = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift registers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_active    <= 1'b0;
            rd_addr_seen <= 1'b0;
            bus.MISO     <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
        end else if (bus.SS_n) begin
            // Deselect aborts any frame; rx_data and rd_addr_seen are kept.
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_active    <= 1'b0;
            bus.MISO     <= 1'b0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= frame_done_c;
            if (shift_en_c) begin
                rx_shift <= {rx_shift[FRAME_W-3:0], bus.MOSI};
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
            if (frame_done_c) begin
                bus.rx_data <= rx_word_t'({rx_shift, bus.MOSI});
                if (state == READ_ADD) begin
                    rd_addr_seen <= 1'b1;
                end else if (state == READ_DATA) begin
                    rd_addr_seen <= 1'b0;
                end
            end
            if (tx_load_c) begin
                bus.MISO  <= bus.tx_data[DATA_W-1];
                tx_shift  <= {bus.tx_data[DATA_W-2:0], 1'b0};
                tx_cnt    <= CNT_W'(DATA_W - 1);
                tx_active <= 1'b1;
            end else if (tx_shift_c) begin
                if (tx_cnt != '0) begin
                    bus.MISO <= tx_shift[DATA_W-1];
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    tx_cnt   <= tx_cnt - CNT_W'(1);
                end else begin
                    bus.MISO <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial-to-parallel front end for the single-port RAM. It receives 11-bit SPI frames on MOSI while SS_n is low, decodes the read/write command bit, and presents each 10-bit word (command[9:8] plus address or data[7:0]) to the RAM as rx_data with a one-cycle rx_valid strobe. On read-data frames it captures the RAM's tx_data/tx_valid response and shifts the byte out on MISO, MSB first. It sits directly upstream of the RAM and also consumes the RAM's read output.

## Interface
- No parameters. Frame width 10 and read width 8 are fixed package constants.
- clk       input   1   system clock; all logic on rising edge
- rst_n     input   1   synchronous, active-low reset
- SS_n      input   1   SPI slave select, active low; sampled on clk
- MOSI      input   1   serial data in, sampled on clk
- MISO      output  1   serial data out
- rx_data   output  10  parallel word to RAM din: [9:8] command, [7:0] payload
- rx_valid  output  1   one-cycle strobe; rx_data is valid when high
- tx_data   input   8   RAM read data
- tx_valid  input   1   RAM read data valid

## Operation
- The FSM has five states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 goes to CHK_CMD; otherwise stays in IDLE.
- CHK_CMD: SS_n=1 goes to IDLE. Otherwise MOSI=0 goes to WRITE. MOSI=1 with rd_addr_seen=0 goes to READ_ADD. MOSI=1 with rd_addr_seen=1 goes to READ_DATA.
- WRITE, READ_ADD and READ_DATA each shift in 10 MOSI bits, MSB first, into rx_data using a 4-bit counter.
- After the 10th bit, rx_valid=1 for exactly one cycle.
- rd_addr_seen is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes.
- READ_DATA, after rx_valid: wait for tx_valid=1, then load tx_data into the output shift register and drive 8 bits on MISO, MSB first, one per cycle.
- While waiting, tx_valid is ignored in every other state or phase.
- The slave stays in its current state after the frame completes until SS_n=1, which returns it to IDLE.
- SS_n=1 at any edge returns the slave to IDLE on that edge. This applies mid-frame and mid-readout.
- On an abort: the counter and shift register clear, rx_valid is not asserted, MISO goes to 0, rx_data holds its last value, and rd_addr_seen is unchanged.
- Extra MOSI bits after the 10th bit of a frame are ignored.
- Reset values: all outputs 0 (rx_data=0, rx_valid=0, MISO=0), state=IDLE, rd_addr_seen=0, counters=0. Reset wins over every other event.

## Timing
- Edges are numbered from E0, the first edge at which IDLE samples SS_n=0.
- E1 samples the command bit.
- E2..E11 sample rx_data[9]..rx_data[0].
- rx_valid is high in the cycle after E11 only; it is cleared at E12.
- The RAM samples rx_valid at E12 and returns tx_valid after E12.
- At E13 the slave samples tx_valid=1 and loads tx_data. MISO=tx_data[7] from E13, then bits 6..0 after E14..E20. MISO=0 from E21.
- If tx_valid arrives later, the readout shifts by the same number of cycles.
- The master must hold SS_n low through E11 for write and address frames, and through E20 for read-data frames.
- Back-to-back frames need SS_n high for at least one edge between them.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA)
  - the command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - FRAME_W=10 and DATA_W=8
- The RAM uses the same package.
- No sub-module: the FSM, counter and shift registers stay in one module.
- A separate spi_ram_top instantiates spi_slave and RAM, connecting rx_data/rx_valid to din/rx_valid and dout/tx_valid to tx_data/tx_valid.

## Test plan
- Write address: SS_n low, MOSI = 0, 00_0001_0110 -> rx_data=10'h016, one-cycle rx_valid after E11; MISO stays 0.
- Write data: SS_n low, MOSI = 0, 01_1010_0101 -> rx_data=10'h1A5 with rx_valid; RAM[0x16]=0xA5 in the top-level bench.
- Read sequence: read-address frame 1, 10_0001_0110 sets rd_addr_seen. Then read-data frame 1, 11_xxxx_xxxx with tx_data=0xA5 and tx_valid after E12 -> MISO=1,0,1,0,0,1,0,1 after E13..E20; rd_addr_seen cleared.
- Read-data frame with rd_addr_seen=0 -> decoded as READ_ADD (rx_data[9:8] as sent); no MISO activity.
- Abort: SS_n high after E6 of a write frame -> no rx_valid, state=IDLE next edge; the next full frame decodes correctly.
- Reset: rst_n=0 mid-readout (after E15) -> MISO=0, rx_valid=0, state=IDLE, rd_addr_seen=0 at the next edge.
